// File: rtl/mips_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: merges load-use, branch redirect,
// HI/LO interlock and data-memory wait states into one set of stage-register controls.
module mips_pipe_ctrl #(
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             br_taken_ex,
  input  logic             md_start_ex,
  input  logic             md_use_id,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             md_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MD_W   = $clog2(MD_LATENCY);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } ctrlState_e;

  ctrlState_e        stateQ, stateD;
  logic [WAIT_W-1:0] waitCntQ, waitCntD;
  logic [MD_W-1:0]   mdCntQ;
  logic              mdPending;
  logic              evalHazards;

  assign mdPending = (mdCntQ != '0);

  // NOTE: every output and next-state signal gets a default before any branch, so no
  // path through this block can leave a value unassigned and infer a latch.
  always_comb begin
    stateD       = stateQ;
    waitCntD     = waitCntQ;
    evalHazards  = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mem_timeout  = 1'b0;
    md_busy      = mdPending;

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      md_busy      = 1'b0;
    end else begin
      unique case (stateQ)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            stateD       = MEM_WAIT;
            waitCntD     = WAIT_W'(1);
          end else begin
            evalHazards = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            if (waitCntQ == WAIT_W'(MEM_TIMEOUT - 1)) begin
              stateD = ERR;
            end else begin
              waitCntD = waitCntQ + WAIT_W'(1);
            end
          end else begin
            // The branch held in the frozen EX stage is acted on in this release cycle.
            evalHazards = 1'b1;
            stateD      = RUN;
            waitCntD    = '0;
          end
        end
        default: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_timeout  = 1'b1;
        end
      endcase

      if (evalHazards) begin
        if (br_taken_ex) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if ((md_use_id && mdPending) || hz_stall) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    end
  end

  // NOTE: reset is sampled on the clock edge like any other input; it is not in the
  // sensitivity list, and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ      <= RUN;
      waitCntQ    <= '0;
      mdCntQ      <= '0;
      stall_count <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;

      // The MUL/DIV unit free-runs, so its countdown continues through freezes.
      if (md_start_ex && ex_mem_write && !mdPending) begin
        mdCntQ <= MD_W'(MD_LATENCY - 1);
      end else if (mdPending) begin
        mdCntQ <= mdCntQ - MD_W'(1);
      end

      if (!pc_write && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule
